tdelay_meter: RTL and testbench

TDELAY_METER -- requirements
Module: tdelay_meter

---
 rtl/tdelay_meter.sv | 125 ++++++++++++
 tb/tb_tdelay_meter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tdelay_meter.sv
// tdelay_meter: measures inverter propagation delay, in clock cycles, over a run of alternating edges
// Ports: clk, rst (asynchronous, active-high)
//        start, n_trials         : run request and number of edges to measure
//        dut_in, dut_out         : registered stimulus to, and raw response from, the inverter
//        busy, done, err         : run in progress, end-of-run pulse, sticky timeout of last run
//        delay_sum, delay_max    : sum and largest of the per-trial cycle counts
//        trials_done             : trials recorded in the last run
module tdelay_meter #(
    parameter int SETTLE_CYC = 8,
    parameter int TIMEOUT    = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  n_trials,
    output logic        dut_in,
    input  logic        dut_out,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [23:0] delay_sum,
    output logic [15:0] delay_max,
    output logic [7:0]  trials_done
);
    typedef enum logic [2:0] {IDLE, SETTLE, LAUNCH, WAIT, DONE} state_t;
    localparam logic [15:0] SET_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    state_t      state;
    logic        s1, out_sync, match;
    logic [7:0]  n_lat;
    logic [15:0] cnt, scnt;
    // The inverter has answered once its synchronized output is the complement of the stimulus
    assign match = out_sync ^ dut_in;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            s1          <= 1'b0;
            out_sync    <= 1'b0;
            dut_in      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            delay_sum   <= '0;
            delay_max   <= '0;
            trials_done <= '0;
            n_lat       <= '0;
            cnt         <= '0;
            scnt        <= '0;
        end else begin
            s1       <= dut_out;
            out_sync <= s1;
            done     <= 1'b0;
            case (state)
                // DONE already has busy low, so it accepts a start exactly like IDLE
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        err         <= 1'b0;
                        delay_sum   <= '0;
                        delay_max   <= '0;
                        trials_done <= '0;
                        n_lat       <= n_trials;
                        cnt         <= '0;
                        scnt        <= '0;
                        if (n_trials == 8'd0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= SETTLE;
                        end
                    end
                end
                // scnt counts consecutive settled cycles, cnt consecutive unsettled ones
                SETTLE: begin
                    if (match) begin
                        cnt <= '0;
                        if (scnt == SET_LAST) state <= LAUNCH;
                        else scnt <= scnt + 16'd1;
                    end else begin
                        scnt <= '0;
                        if (cnt == TMO_LAST) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end
                LAUNCH: begin
                    dut_in <= ~dut_in;
                    cnt    <= '0;
                    state  <= WAIT;
                end
                // Two synchronizer stages make a zero-delay inverter read as a count of 2
                WAIT: begin
                    if (match) begin
                        delay_sum   <= delay_sum + 24'(cnt);
                        delay_max   <= (cnt > delay_max) ? cnt : delay_max;
                        trials_done <= trials_done + 8'd1;
                        cnt         <= '0;
                        scnt        <= '0;
                        if (trials_done + 8'd1 == n_lat) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= SETTLE;
                        end
                    end else if (cnt == TMO_LAST) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tdelay_meter.sv
// tb_tdelay_meter: randomized and directed runs of tdelay_meter against an inverter model and a run-level reference
module tb_tdelay_meter;
    localparam int TMO = 20;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  n_trials = '0;
    logic        dut_in, dut_out, busy, done, err;
    logic [23:0] delay_sum;
    logic [15:0] delay_max;
    logic [7:0]  trials_done;

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;
    bit chk_en = 0;
    int exp_sum = 0, exp_max = 0, exp_tr = 0;
    bit exp_err = 0, exp_lvl = 0;

    // inverter model: output follows ~dut_in after drise/dfall whole cycles; optional stuck-low fault
    int drise = 0, dfall = 0;
    bit stuck_arm = 0, stuck = 0;
    bit prev_in = 0;
    int since = 1000;

    tdelay_meter #(.SETTLE_CYC(8), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .n_trials(n_trials),
        .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done), .err(err),
        .delay_sum(delay_sum), .delay_max(delay_max), .trials_done(trials_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!stuck_arm) stuck = 0;
        if (dut_in !== prev_in) begin
            prev_in = dut_in;
            since = 0;
            if (stuck_arm && dut_in) stuck = 1;
        end else if (since < 1000) begin
            since++;
        end
    end

    always_comb dut_out = stuck ? 1'b0 : ((since >= (prev_in ? dfall : drise)) ? ~prev_in : prev_in);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // run-level reference: each recorded trial costs 2 + inverter delay cycles
    task automatic model(input int n, input int dr, input int df, input bit arm, input bit lvl0,
                         output int sum, output int mx, output int tr, output bit e, output bit lvl);
        bit s = 0;
        int c;
        lvl = lvl0; sum = 0; mx = 0; tr = 0; e = 0;
        for (int k = 0; k < n; k++) begin
            if (s && !lvl) begin e = 1; break; end
            lvl = ~lvl;
            if (arm && lvl) s = 1;
            if (s && !lvl) begin e = 1; break; end
            c = 2 + (s ? 0 : (lvl ? df : dr));
            if (c >= TMO) begin e = 1; break; end
            sum += c;
            if (c > mx) mx = c;
            tr++;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                n_done++;
                check("end_sum", 32'(delay_sum), exp_sum);
                check("end_max", 32'(delay_max), exp_max);
                check("end_trials", 32'(trials_done), exp_tr);
                check("end_err", 32'(err), 32'(exp_err));
                check("end_dut_in", 32'(dut_in), 32'(exp_lvl));
                check("end_busy", 32'(busy), 0);
            end else if (chk_en) begin
                check("hold_sum", 32'(delay_sum), exp_sum);
                check("hold_max", 32'(delay_max), exp_max);
                check("hold_trials", 32'(trials_done), exp_tr);
                check("hold_err", 32'(err), 32'(exp_err));
                check("hold_busy", 32'(busy), 0);
            end
        end
    end

    task automatic run_start(input int n, input int dr, input int df, input bit arm);
        bit l0;
        @(negedge clk);
        chk_en = 0;
        drise = dr; dfall = df; stuck_arm = arm;
        l0 = exp_lvl;
        model(n, dr, df, arm, l0, exp_sum, exp_max, exp_tr, exp_err, exp_lvl);
        n_done = 0;
        start = 1'b1;
        n_trials = 8'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_wait();
        int c = 0;
        while (!done && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check("done_seen", 32'(done), 1);
        chk_en = 1;
        repeat (3) @(negedge clk);
        check("done_pulses", n_done, 1);
        stuck_arm = 0;
    endtask

    task automatic wait_toggles(input int n);
        int c = 0, t = 0;
        logic last = dut_in;
        while (t < n && c < 500) begin
            @(posedge clk);
            #1;
            c++;
            if (dut_in !== last) begin t++; last = dut_in; end
        end
        check("toggles_seen", t, n);
    endtask

    initial begin
        #1;
        check("rst_dut_in", 32'(dut_in), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sum", 32'(delay_sum), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1;

        run_start(4, 0, 0, 0);
        run_wait();
        check("z4_sum", 32'(delay_sum), 8);
        check("z4_max", 32'(delay_max), 2);
        check("z4_trials", 32'(trials_done), 4);
        check("z4_err", 32'(err), 0);
        check("z4_dut_in", 32'(dut_in), 0);

        run_start(2, 1, 3, 0);
        drise = 3; dfall = 1;
        exp_lvl = 0;
        model(2, 3, 1, 0, 0, exp_sum, exp_max, exp_tr, exp_err, exp_lvl);
        run_wait();
        check("asym_sum", 32'(delay_sum), 8);
        check("asym_max", 32'(delay_max), 5);
        check("asym_err", 32'(err), 0);

        run_start(3, 0, 0, 1);
        run_wait();
        check("stuck_err", 32'(err), 1);
        check("stuck_trials", 32'(trials_done), 1);

        run_start(0, 0, 0, 0);
        check("zero_done", 32'(done), 1);
        check("zero_busy", 32'(busy), 0);
        run_wait();
        check("zero_sum", 32'(delay_sum), 0);
        check("zero_dut_in", 32'(dut_in), 0);

        run_start(3, 0, 0, 0);
        wait_toggles(1);
        @(negedge clk);
        start = 1'b1; n_trials = 8'd7;
        @(negedge clk);
        start = 1'b0;
        run_wait();
        check("busy_start_trials", 32'(trials_done), 3);

        for (int i = 0; i < 10; i++) begin
            run_start($urandom_range(1, 6), $urandom_range(0, 4), $urandom_range(0, 4), 0);
            run_wait();
        end

        run_start(3, 0, 0, 0);
        wait_toggles(2);
        check("pre_rst_trials", 32'(trials_done), 1);
        #3;
        rst = 1'b1;
        #1;
        check("arst_dut_in", 32'(dut_in), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_err", 32'(err), 0);
        check("arst_sum", 32'(delay_sum), 0);
        check("arst_max", 32'(delay_max), 0);
        check("arst_trials", 32'(trials_done), 0);
        exp_sum = 0; exp_max = 0; exp_tr = 0; exp_err = 0; exp_lvl = 0;
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1;
        run_start(1, 0, 0, 0);
        run_wait();
        check("post_rst_sum", 32'(delay_sum), 2);
        check("post_rst_dut_in", 32'(dut_in), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
